// File: rtl/ntt_pkg.sv
// Shared NTT constants: data/address width defaults, result bank-pair mapping
// and the result reader state encoding.
package ntt_pkg;

  localparam int NTT_DATA_W = 32;
  localparam int NTT_ADDR_W = 8;

  localparam logic [1:0] BANK_PAIR_LO = 2'd0;
  localparam logic [1:0] BANK_PAIR_HI = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

  // Even coefficients live in the first bank of a pair, odd ones in the second.
  function automatic logic [1:0] coef_bank(input logic bank_sel, input logic k_lsb);
    return (bank_sel ? BANK_PAIR_HI : BANK_PAIR_LO) | {1'b0, k_lsb};
  endfunction

endpackage

// File: rtl/ntt_rd_fifo.sv
// Small synchronous FIFO buffering coefficients (plus last flag) between the
// bank reads and the output handshake.
module ntt_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/ntt_result_reader.sv
// Streams a finished transform out of a bank pair in natural coefficient order
// over a valid/ready interface, reading one coefficient per cycle when space allows.
module ntt_result_reader
  import ntt_pkg::*;
#(
  parameter int DATA_W = NTT_DATA_W,
  parameter int ADDR_W = NTT_ADDR_W,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank_sel,
  output logic [3:0]        ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout0,
  input  logic [DATA_W-1:0] ram_dout1,
  input  logic [DATA_W-1:0] ram_dout2,
  input  logic [DATA_W-1:0] ram_dout3,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_D) + 1;

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W:0]   rd_idx;
  logic              bank_q;
  logic              infl;
  logic              infl_last;
  logic [1:0]        infl_bank;
  logic              issue;
  logic              is_last;
  logic              start_acc;
  logic              pop;
  logic              room;
  logic [1:0]        issue_bank;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;

  assign start_acc  = (state == ST_IDLE) && start;
  assign is_last    = (rd_idx == '1);
  assign issue_bank = coef_bank(bank_q, rd_idx[0]);
  assign pop        = m_valid && m_ready;

  // A read already in flight will land next cycle, so it reserves a slot too.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, infl};
  assign room      = !fifo_full && (occupancy < (CNT_W+1)'(FIFO_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_idx    <= '0;
      bank_q    <= 1'b0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      infl_bank <= 2'd0;
    end else begin
      state     <= state_nxt;
      infl      <= issue;
      infl_last <= issue && is_last;
      infl_bank <= issue_bank;
      if (start_acc) begin
        rd_idx <= '0;
        bank_q <= bank_sel;
      end else if (issue && !is_last) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        issue = room;
        if (room && is_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as the final coefficient is accepted so done follows it directly.
        if (!infl && (fifo_empty || (fifo_count == CNT_W'(1) && pop)))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_word = ram_dout0;
    case (infl_bank)
      2'd0:    rd_word = ram_dout0;
      2'd1:    rd_word = ram_dout1;
      2'd2:    rd_word = ram_dout2;
      default: rd_word = ram_dout3;
    endcase
  end

  ntt_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (infl),
    .wr_data ({infl_last, rd_word}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign ram_en   = issue ? (4'b0001 << issue_bank) : 4'b0000;
  assign ram_addr = issue ? rd_idx[ADDR_W:1] : '0;
  assign busy     = (state == ST_READ) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_last   = !fifo_empty && fifo_head[DATA_W];

endmodule

// File: tb/tb_ntt_result_reader.sv
// Scoreboard bench for ntt_result_reader with N=16: the stimulus queues the expected
// coefficients and a negedge monitor checks each accepted transfer against them.
module tb_ntt_result_reader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int FD = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bank_sel = 1'b0;
  logic [3:0]    ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout0 = '0;
  logic [DW-1:0] ram_dout1 = '0;
  logic [DW-1:0] ram_dout2 = '0;
  logic [DW-1:0] ram_dout3 = '0;
  logic          busy;
  logic          done;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] mem [4][8];
  logic [DW:0]   sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int xfer_total = 0;
  int done_total = 0;
  int read_total = 0;
  int lo_en_total = 0;
  int done_cyc = 0;
  int xfer_cyc [256];
  logic busy_at_done = 1'b0;

  ntt_result_reader #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .FIFO_D (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bank_sel  (bank_sel),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout0 (ram_dout0),
    .ram_dout1 (ram_dout1),
    .ram_dout2 (ram_dout2),
    .ram_dout3 (ram_dout3),
    .busy      (busy),
    .done      (done),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en[0]) ram_dout0 <= mem[0][ram_addr];
    if (ram_en[1]) ram_dout1 <= mem[1][ram_addr];
    if (ram_en[2]) ram_dout2 <= mem[2][ram_addr];
    if (ram_en[3]) ram_dout3 <= mem[3][ram_addr];
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadBanks(input bit dead_lo);
    for (int a = 0; a < 8; a++) begin
      mem[0][a] = dead_lo ? 32'hDEAD : 32'(2 * a);
      mem[1][a] = dead_lo ? 32'hDEAD : 32'(2 * a + 1);
      mem[2][a] = 32'(100 + 2 * a);
      mem[3][a] = 32'(101 + 2 * a);
    end
  endtask

  // Queue the expected stream, then pulse start and flip bank_sel straight after.
  task automatic applyStimulus(input logic bsel, output int start_cyc);
    for (int k = 0; k < N; k++)
      sb.push_back({(k == N - 1), (bsel ? 32'(100 + k) : 32'(k))});
    @(posedge clk);
    #1;
    bank_sel = bsel;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bank_sel = ~bsel;
    start_cyc = cyc;
  endtask

  task automatic finishRun(input string name, input int xbase, input int dbase);
    for (int i = 0; i < 300 && done_total == dbase; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checkOutput({name, "_done_count"}, done_total - dbase, 1);
    checkOutput({name, "_xfers"}, xfer_total - xbase, N);
    checkOutput({name, "_sb_left"}, sb.size(), 0);
    checkOutput({name, "_done_after_last"}, done_cyc, xfer_cyc[xbase + N - 1] + 1);
    checkOutput({name, "_busy_at_done"}, busy_at_done, 0);
  endtask

  initial begin
    logic [DW:0] exp_word;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (ram_en != 4'b0) read_total++;
        if (ram_en[1:0] != 2'b0) lo_en_total++;
        if (prev_stall) begin
          checkOutput("stall_valid", m_valid, 1);
          checkOutput("stall_hold", {m_last, m_data}, prev_word);
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checkOutput("xfer_expected", sb.size(), 1);
          end else begin
            exp_word = sb.pop_front();
            checkOutput("xfer_data", m_data, exp_word[DW-1:0]);
            checkOutput("xfer_last", m_last, exp_word[DW]);
          end
          xfer_cyc[xfer_total] = cyc;
          xfer_total++;
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_last, m_data};
        if (done) begin
          done_total++;
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  initial begin
    int s_cyc;
    int xbase;
    int dbase;
    int base_cnt;

    loadBanks(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_last", m_last, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] run 1: bank pair 0, always ready");
    ready_mode = 0;
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    finishRun("run1", xbase, dbase);
    checkOutput("run1_first_latency", xfer_cyc[xbase], s_cyc + 2);
    checkOutput("run1_back_to_back", xfer_cyc[xbase + N - 1] - xfer_cyc[xbase], N - 1);

    $display("[TB] run 2: bank pair 1, low banks poisoned");
    loadBanks(1'b1);
    base_cnt = lo_en_total;
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b1, s_cyc);
    finishRun("run2", xbase, dbase);
    checkOutput("run2_low_bank_reads", lo_en_total - base_cnt, 0);
    loadBanks(1'b0);

    $display("[TB] run 3: random ready");
    ready_mode = 1;
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    finishRun("run3", xbase, dbase);

    $display("[TB] run 4: ready held low for 20 cycles");
    ready_mode = 2;
    repeat (2) @(posedge clk);
    base_cnt = read_total;
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    repeat (20) @(posedge clk);
    checkOutput("run4_reads_bounded", (read_total - base_cnt) <= FD, 1);
    checkOutput("run4_valid_while_stalled", m_valid, 1);
    ready_mode = 0;
    finishRun("run4", xbase, dbase);

    $display("[TB] run 5: second start mid-run");
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bank_sel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bank_sel = 1'b0;
    finishRun("run5", xbase, dbase);

    $display("[TB] run 6: reset after transfer 7");
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    for (int i = 0; i < 100 && (xfer_total - xbase) < 7; i++) @(posedge clk);
    checkOutput("run6_reached_7", (xfer_total - xbase) >= 7, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_valid", m_valid, 0);
    checkOutput("abort_data", m_data, 0);
    checkOutput("abort_last", m_last, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ram_en", ram_en, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    checkOutput("abort_no_done", done_total - dbase, 0);
    xbase = xfer_total;
    dbase = done_total;
    applyStimulus(1'b0, s_cyc);
    finishRun("run6_restart", xbase, dbase);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
